// File: rtl/gray_fifo_wr_ctrl_pkg.sv
// Shared types and helpers for the gray FIFO write-side controller.
package gray_fifo_wr_ctrl_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // Modular pointer difference; callers truncate to their pointer width
  function automatic logic [PTR_MAX_W-1:0] ptr_diff(
    input logic [PTR_MAX_W-1:0] wr_ptr,
    input logic [PTR_MAX_W-1:0] rd_ptr
  );
    return wr_ptr - rd_ptr;
  endfunction

endpackage

// File: rtl/gray_fifo_wr_ctrl_if.sv
// Client write handshake plus RAM write port of the FIFO write controller.
interface gray_fifo_wr_ctrl_if #(
  parameter int unsigned AWIDTH = 4
);

  logic              src_rdy_i;
  logic              dst_rdy_o;
  logic              wr_en_o;
  logic [AWIDTH-1:0] wr_addr_o;

  modport master (
    input  src_rdy_i,
    output dst_rdy_o,
    output wr_en_o,
    output wr_addr_o
  );

  modport slave (
    output src_rdy_i,
    input  dst_rdy_o,
    input  wr_en_o,
    input  wr_addr_o
  );

endinterface

// File: rtl/gray_fifo_space_calc.sv
// Combinational occupancy math from the write and (synchronized) read pointers.
module gray_fifo_space_calc
  import gray_fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = 4
) (
  input  logic [AWIDTH:0] wr_ptr,
  input  logic [AWIDTH:0] rd_ptr,
  output logic [AWIDTH:0] used_c,
  output logic [AWIDTH:0] space_c,
  output logic            full_c,
  output logic            over_c
);

  localparam int unsigned PW = AWIDTH + 1;
  localparam logic [AWIDTH:0] DEPTH = PW'(2 ** AWIDTH);

  // used wraps modulo 2**(AWIDTH+1); space saturates when pointers are inconsistent
  always_comb begin
    used_c  = PW'(ptr_diff(PTR_MAX_W'(wr_ptr), PTR_MAX_W'(rd_ptr)));
    over_c  = (used_c > DEPTH);
    full_c  = (used_c == DEPTH);
    space_c = over_c ? '0 : (DEPTH - used_c);
  end

endmodule

// File: rtl/gray_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO. The bin-to-gray pointer
// synchronizer is instantiated alongside this block at top level.
// Optional almost-full flag: define GRAY_FIFO_WR_CTRL_ALMOST_FULL_EN.
module gray_fifo_wr_ctrl
  import gray_fifo_wr_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = 4
`ifdef GRAY_FIFO_WR_CTRL_ALMOST_FULL_EN
  , parameter int unsigned AF_THRESH = 2
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       flush_i,
  gray_fifo_wr_ctrl_if.master        wif,
  output logic [AWIDTH:0]            wr_ptr_o,
  input  logic [AWIDTH:0]            rd_ptr_i,
  output logic [AWIDTH:0]            space_o,
  output logic                       full_o,
  output logic                       flush_done_o,
  output logic                       overrun_err_o
`ifdef GRAY_FIFO_WR_CTRL_ALMOST_FULL_EN
  , output logic                     almost_full_o
`endif
);

  localparam int unsigned PW = AWIDTH + 1;

  wr_state_e       state;
  logic [AWIDTH:0] used_c;
  logic            over_c;
  logic            accept_c;

  gray_fifo_space_calc #(
    .AWIDTH (AWIDTH)
  ) u_space_calc (
    .wr_ptr  (wr_ptr_o),
    .rd_ptr  (rd_ptr_i),
    .used_c  (used_c),
    .space_c (space_o),
    .full_c  (full_o),
    .over_c  (over_c)
  );

  // Same-cycle handshake; RAM address is the pointer without its wrap bit
  assign wif.dst_rdy_o = (state == ST_RUN) && !full_o;
  assign accept_c      = wif.src_rdy_i && wif.dst_rdy_o;
  assign wif.wr_en_o   = accept_c;
  assign wif.wr_addr_o = wr_ptr_o[AWIDTH-1:0];

`ifdef GRAY_FIFO_WR_CTRL_ALMOST_FULL_EN
  assign almost_full_o = (space_o <= PW'(AF_THRESH));
`endif

  // Controller FSM, write pointer, flush-done pulse and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wr_ptr_o      <= '0;
      flush_done_o  <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      if (accept_c) begin
        wr_ptr_o <= wr_ptr_o + PW'(1);
      end
      if (over_c) begin
        overrun_err_o <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (en_i) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en_i) begin
            state <= ST_IDLE;
          end else if (flush_i) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!en_i) begin
            state <= ST_IDLE;
          end else if (used_c == '0) begin
            state        <= ST_DONE;
            flush_done_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= en_i ? ST_RUN : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gray_fifo_wr_ctrl.md
GRAY_FIFO_WR_CTRL -- requirements
Module: gray_fifo_wr_ctrl

Interface
REQ-001 Parameter AWIDTH, default 4, SHALL set the address width; DEPTH = 2**AWIDTH entries.
REQ-002 Parameter AF_THRESH, default 2, SHALL set the almost-full free-space threshold; it is present only with the macro in REQ-025.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 en_i  in  1  SHALL be the controller enable.
REQ-006 flush_i  in  1  SHALL be a one-cycle request to block writes until the FIFO drains.
REQ-007 src_rdy_i  in  1  SHALL indicate that the client offers a write.
REQ-008 dst_rdy_o  out  1  SHALL indicate that the controller accepts a write this cycle.
REQ-009 wr_en_o  out  1  SHALL be the RAM write strobe.
REQ-010 wr_addr_o  out  AWIDTH  SHALL be the RAM write address.
REQ-011 wr_ptr_o  out  AWIDTH+1  SHALL be the binary write pointer sent to the read domain.
REQ-012 rd_ptr_i  in  AWIDTH+1  SHALL be the binary read pointer, already synchronized into clk.
REQ-013 space_o  out  AWIDTH+1  SHALL give the free entries.
REQ-014 full_o  out  1  SHALL indicate that the FIFO is full.
REQ-015 flush_done_o  out  1  SHALL pulse when a flush completes.
REQ-016 overrun_err_o  out  1  SHALL be the sticky pointer-inconsistency flag.
REQ-017 almost_full_o  out  1  SHALL indicate that space is at or below AF_THRESH; it is present only with the macro in REQ-025.

Function
REQ-018 Arithmetic SHALL use the following rules:
- used = (wr_ptr_o - rd_ptr_i) modulo 2**(AWIDTH+1);
- full_o = (used == DEPTH);
- space_o = DEPTH - used, saturating at 0 when used > DEPTH.
- full_o and space_o are combinational from registered wr_ptr_o and rd_ptr_i.
REQ-019 The FSM SHALL have the states IDLE, RUN, FLUSH and DONE, with these transitions:
- IDLE->RUN when en_i=1;
- RUN->IDLE when en_i=0;
- RUN->FLUSH when flush_i=1;
- FLUSH->DONE when used==0;
- DONE->RUN unconditionally after one cycle;
- any state->IDLE when en_i=0, except that DONE completes first.
REQ-020 Write handshake SHALL follow these rules:
- dst_rdy_o = (state==RUN) && !full_o;
- accept = src_rdy_i && dst_rdy_o;
- wr_en_o = accept, combinational, same cycle;
- wr_addr_o = wr_ptr_o[AWIDTH-1:0];
- on accept, wr_ptr_o increments by 1 at the next edge, wrapping modulo 2**(AWIDTH+1).
REQ-021 Latency SHALL be: one accepted write reduces space_o by 1 in the next cycle; read-side frees appear when rd_ptr_i changes, with no additional delay inside this block.
REQ-022 Boundary conditions SHALL behave as follows:
- flush_i together with an accept in RUN: the write is accepted, then the FSM enters FLUSH.
- flush_i outside RUN: ignored.
- full with src_rdy_i=1: no write, pointer held.
- Pointer wrap from 2**(AWIDTH+1)-1 to 0: full and space remain correct.
REQ-023 flush_done_o SHALL be 1 for exactly one cycle, while in DONE.
REQ-024 overrun_err_o SHALL set when used > DEPTH, stay set until reset, and not block operation.

Configuration
REQ-025 The macro GRAY_FIFO_WR_CTRL_ALMOST_FULL_EN SHALL control the almost-full feature:
- defined: almost_full_o = (space_o <= AF_THRESH), and AF_THRESH exists;
- undefined: neither the port nor the parameter exists, and all other behaviour is identical.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, wr_ptr_o=0, overrun_err_o=0, flush_done_o=0, dst_rdy_o=0, wr_en_o=0.
REQ-027 With rd_ptr_i=0 during reset: space_o=DEPTH, full_o=0.
REQ-028 Reset mid-flush or mid-write SHALL abort the operation; no write completes after rst_n falls.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, FLUSH, DONE) and the pointer-difference function.
REQ-030 One sub-module, gray_fifo_space_calc, SHALL compute used, space, full and error combinationally.
REQ-031 The block SHALL pair with the existing bin-to-gray pointer synchronizer instantiated at top level, not internally.

Verification (AWIDTH=4, DEPTH=16)
REQ-032 Reset, en_i=1, src_rdy_i=1 held, rd_ptr_i=0 -> 16 writes at addresses 0..15; full_o=1 after the 16th; dst_rdy_o=0; wr_ptr_o=16; space_o=0.
REQ-033 Full, then rd_ptr_i stepped 0->1 -> space_o=1 and full_o=0 in the same cycle; the next write goes to address 0; wr_ptr_o=17.
REQ-034 Wrap test: wr_ptr_o=31 with rd_ptr_i=20, one write -> wr_ptr_o=0, used=12, space_o=4.
REQ-035 flush_i with used=5, then rd_ptr_i advanced by 5 over 10 cycles -> dst_rdy_o=0 throughout; flush_done_o high for one cycle after used==0; RUN resumes.
REQ-036 rd_ptr_i = wr_ptr_o+1 (read ahead of write) -> overrun_err_o=1 and held; cleared only by rst_n=0.
REQ-037 With the macro defined and AF_THRESH=2: space_o=3 -> almost_full_o=0; space_o=2 -> almost_full_o=1.
